// File: rtl/fb_pkg.sv
// fb_pkg: shared pixel type, default raster timing and width helper for the frame-store scanout.
package fb_pkg;

    typedef logic [15:0] pixel_t;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    localparam int unsigned PIX_W        = $bits(rgb565_t);

    localparam int unsigned DEF_H_DISP   = 16;
    localparam int unsigned DEF_V_DISP   = 12;
    localparam int unsigned DEF_H_SYNC   = 2;
    localparam int unsigned DEF_H_BPORCH = 2;
    localparam int unsigned DEF_H_FPORCH = 2;
    localparam int unsigned DEF_V_SYNC   = 1;
    localparam int unsigned DEF_V_BPORCH = 1;
    localparam int unsigned DEF_V_FPORCH = 1;
    localparam pixel_t      DEF_BG_COLOR = 16'h0000;

    // Bits needed to index 'depth' entries; never less than one.
    function automatic int unsigned addr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fb_dpram.sv
// fb_dpram: simple dual-port RAM, one write port and one synchronous read port (latency 1).
module fb_dpram #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AW    = 9
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fb_scanout.sv
// fb_scanout: captures RGB565 frames into a double-buffered store and scans the latest complete one out.
// Optional macro FB_SCANOUT_DROP_CNT_EN adds a saturating drop_cnt output.
module fb_scanout
    import fb_pkg::*;
#(
    parameter int unsigned H_DISP   = DEF_H_DISP,
    parameter int unsigned V_DISP   = DEF_V_DISP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BPORCH = DEF_H_BPORCH,
    parameter int unsigned H_FPORCH = DEF_H_FPORCH,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BPORCH = DEF_V_BPORCH,
    parameter int unsigned V_FPORCH = DEF_V_FPORCH,
    parameter pixel_t      BG_COLOR = DEF_BG_COLOR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] data_in,
    input  logic        data_valid,
    input  logic        data_vs,
    output logic        video_hs,
    output logic        video_vs,
    output logic        video_de,
    output logic [15:0] video_data,
    output logic        frame_ready
`ifdef FB_SCANOUT_DROP_CNT_EN
    ,
    output logic [15:0] drop_cnt
`endif
);

    localparam int unsigned H_TOTAL   = H_SYNC + H_BPORCH + H_DISP + H_FPORCH;
    localparam int unsigned V_TOTAL   = V_SYNC + V_BPORCH + V_DISP + V_FPORCH;
    localparam int unsigned FRAME_PIX = H_DISP * V_DISP;
    localparam int unsigned AW        = addr_w(FRAME_PIX);
    localparam int unsigned PW        = AW + 1;
    localparam int unsigned HW        = addr_w(H_TOTAL + 1);
    localparam int unsigned VW        = addr_w(V_TOTAL + 1);

    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_SYNC_E  = HW'(H_SYNC);
    localparam logic [VW-1:0] V_SYNC_E  = VW'(V_SYNC);
    localparam logic [HW-1:0] H_ACT_B   = HW'(H_SYNC + H_BPORCH);
    localparam logic [HW-1:0] H_ACT_E   = HW'(H_SYNC + H_BPORCH + H_DISP);
    localparam logic [VW-1:0] V_ACT_B   = VW'(V_SYNC + V_BPORCH);
    localparam logic [VW-1:0] V_ACT_E   = VW'(V_SYNC + V_BPORCH + V_DISP);
    localparam logic [PW-1:0] PIX_LAST  = PW'(FRAME_PIX - 1);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [AW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr, wr_ptr_d;
    logic          disp_bank, disp_bank_d, wr_bank;
    logic          pending, pending_d;
    logic          wr_lock, wr_lock_d;
    logic          frame_ok, frame_ok_d;
    logic          hs_c, vs_c, de_c, frame_start_c;
    logic          we_c;
    logic [AW:0]   waddr_c;
    logic          de_r;
    pixel_t        ram_q;

    assign wr_bank = ~disp_bank;

    // Raster decode from the free-running counters.
    always_comb begin
        hs_c          = h_cnt < H_SYNC_E;
        vs_c          = v_cnt < V_SYNC_E;
        de_c          = (h_cnt >= H_ACT_B) && (h_cnt < H_ACT_E) &&
                        (v_cnt >= V_ACT_B) && (v_cnt < V_ACT_E);
        frame_start_c = (h_cnt == '0) && (v_cnt == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
        end else if (frame_start_c) begin
            rd_ptr <= '0;
        end else if (de_c) begin
            rd_ptr <= rd_ptr + AW'(1);
        end
    end

    // Capture and bank-swap control; the swap sees pre-edge pending, so a same-cycle write hits the old bank.
    always_comb begin
        wr_ptr_d    = wr_ptr;
        wr_lock_d   = wr_lock;
        pending_d   = pending;
        disp_bank_d = disp_bank;
        frame_ok_d  = frame_ok;
        we_c        = 1'b0;
        waddr_c     = {wr_bank, wr_ptr[AW-1:0]};
        if (data_vs) begin
            wr_ptr_d  = '0;
            wr_lock_d = pending;
            if (data_valid && !pending) begin
                we_c     = 1'b1;
                waddr_c  = {wr_bank, AW'(0)};
                wr_ptr_d = PW'(1);
            end
        end else if (data_valid && !wr_lock && (wr_ptr <= PIX_LAST)) begin
            we_c     = 1'b1;
            wr_ptr_d = wr_ptr + PW'(1);
            if (wr_ptr == PIX_LAST) begin
                pending_d = 1'b1;
                wr_lock_d = 1'b1;
            end
        end
        if (frame_start_c && pending) begin
            disp_bank_d = ~disp_bank;
            pending_d   = 1'b0;
            frame_ok_d  = 1'b1;
            if (!data_vs) begin
                wr_lock_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            wr_lock   <= 1'b0;
            pending   <= 1'b0;
            disp_bank <= 1'b0;
            frame_ok  <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr_d;
            wr_lock   <= wr_lock_d;
            pending   <= pending_d;
            disp_bank <= disp_bank_d;
            frame_ok  <= frame_ok_d;
        end
    end

    fb_dpram #(
        .WIDTH (PIX_W),
        .AW    (AW + 1)
    ) u_ram (
        .clk   (clk),
        .we    (we_c),
        .waddr (waddr_c),
        .wdata (data_in),
        .re    (de_c),
        .raddr ({disp_bank, rd_ptr}),
        .rdata (ram_q)
    );

    // Sync/enable delayed one clock to line up with the RAM read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            video_hs <= 1'b0;
            video_vs <= 1'b0;
            de_r     <= 1'b0;
        end else begin
            video_hs <= hs_c;
            video_vs <= vs_c;
            de_r     <= de_c;
        end
    end

    assign video_de    = de_r;
    assign frame_ready = frame_ok;

    always_comb begin
        video_data = '0;
        if (de_r) begin
            video_data = frame_ok ? ram_q : BG_COLOR;
        end
    end

`ifdef FB_SCANOUT_DROP_CNT_EN
    logic drop_c;

    // A frame start while one is pending, or one that cuts a partially captured frame.
    always_comb begin
        drop_c = data_vs && (pending || (!wr_lock && (wr_ptr != '0) && (wr_ptr <= PIX_LAST)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop_c && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fb_scanout.sv
// tb_fb_scanout: frame-level reference model of capture, bank swap and raster scanout for fb_scanout.
// Also covers drop_cnt when built with FB_SCANOUT_DROP_CNT_EN.
module tb_fb_scanout;

    localparam int H_TOTAL = 22;
    localparam int V_TOTAL = 15;
    localparam int F_TOTAL = H_TOTAL * V_TOTAL;
    localparam int NPIX    = 192;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data_in = '0;
    logic        data_valid = 1'b0;
    logic        data_vs = 1'b0;
    logic        video_hs, video_vs, video_de, frame_ready;
    logic [15:0] video_data;
`ifdef FB_SCANOUT_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    always #5 clk = ~clk;

    fb_scanout dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .data_vs     (data_vs),
        .video_hs    (video_hs),
        .video_vs    (video_vs),
        .video_de    (video_de),
        .video_data  (video_data),
        .frame_ready (frame_ready)
`ifdef FB_SCANOUT_DROP_CNT_EN
        ,
        .drop_cnt    (drop_cnt)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: frames as arrays, raster position as a plain cycle index.
    int pos;
    int cap_q[$];
    bit m_lock, m_pend, m_shown;
    int pend_frame[NPIX];
    int disp_frame[NPIX];
    int m_drop;
    int first_px, last_px;
    int de_seen, hs_seen, vs_seen;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        pos = 0;
        cap_q.delete();
        m_lock  = 1'b0;
        m_pend  = 1'b0;
        m_shown = 1'b0;
        m_drop  = 0;
    endtask

    task automatic step(input bit vs, input bit valid, input int unsigned data);
        int h, v, idx, e_data, p_now, exp_v, act_v;
        bit e_hs, e_vs, e_de, old_pend, old_lock;
        int d;
        d          = int'(data & 32'hFFFF);
        data_vs    = vs;
        data_valid = valid;
        data_in    = 16'(d);
        @(posedge clk);
        p_now = pos;
        h     = pos % H_TOTAL;
        v     = pos / H_TOTAL;
        e_hs  = (h < 2);
        e_vs  = (v < 1);
        e_de  = (h >= 4) && (h < 20) && (v >= 2) && (v < 14);
        old_pend = m_pend;
        old_lock = m_lock;
        if (vs) begin
            if (old_pend || (!old_lock && cap_q.size() > 0 && cap_q.size() < NPIX))
                m_drop = (m_drop < 65535) ? m_drop + 1 : 65535;
            cap_q.delete();
            m_lock = old_pend;
            if (valid && !old_pend) cap_q.push_back(d);
        end else if (valid && !old_lock && cap_q.size() < NPIX) begin
            cap_q.push_back(d);
            if (cap_q.size() == NPIX) begin
                foreach (pend_frame[i]) pend_frame[i] = cap_q[i];
                m_pend = 1'b1;
                m_lock = 1'b1;
            end
        end
        if (p_now == 0 && old_pend) begin
            disp_frame = pend_frame;
            m_shown    = 1'b1;
            m_pend     = 1'b0;
            if (!vs) m_lock = 1'b0;
        end
        idx    = (v - 2) * 16 + (h - 4);
        e_data = (e_de && m_shown) ? disp_frame[idx] : 0;
        pos    = (pos + 1) % F_TOTAL;
        @(negedge clk);
        exp_v = int'({e_hs, e_vs, e_de, m_shown, 16'(e_data)});
        act_v = int'({video_hs, video_vs, video_de, frame_ready, video_data});
        check($sformatf("outputs@pos%0d {hs,vs,de,ready,data}", p_now), act_v, exp_v);
`ifdef FB_SCANOUT_DROP_CNT_EN
        check($sformatf("drop_cnt@pos%0d", p_now), int'(drop_cnt), m_drop);
`endif
        if (video_de) de_seen++;
        if (video_hs) hs_seen++;
        if (video_vs) vs_seen++;
        if (e_de && idx == 0)        first_px = int'(video_data);
        if (e_de && idx == NPIX - 1) last_px  = int'(video_data);
    endtask

    task automatic run_to(input int p);
        for (int i = 0; i < F_TOTAL && pos != p; i++) step(1'b0, 1'b0, 0);
    endtask

    task automatic feed(input int base, input int n);
        for (int i = 0; i < n; i++) step(i == 0, 1'b1, 32'(base + i));
    endtask

    // Runs one whole display frame from its start, recording first/last active pixel.
    task automatic show_frame();
        run_to(0);
        first_px = -1;
        last_px  = -1;
        de_seen  = 0;
        hs_seen  = 0;
        vs_seen  = 0;
        step(1'b0, 1'b0, 0);
        run_to(0);
    endtask

    typedef struct {
        int base;
        int npix;
        int exp_first;
        int exp_last;
        bit exp_ready;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{base: 0,    npix: 192, exp_first: 0,   exp_last: 191, exp_ready: 1'b1};
        vecs[1] = '{base: 2000, npix: 100, exp_first: 0,   exp_last: 191, exp_ready: 1'b1};
        vecs[2] = '{base: 500,  npix: 192, exp_first: 500, exp_last: 691, exp_ready: 1'b1};
        vecs[3] = '{base: 0,    npix: 200, exp_first: 0,   exp_last: 191, exp_ready: 1'b1};

        repeat (3) @(negedge clk);
        check("reset outputs", int'({video_hs, video_vs, video_de, frame_ready, video_data}), 0);
`ifdef FB_SCANOUT_DROP_CNT_EN
        check("reset drop_cnt", int'(drop_cnt), 0);
`endif
        rst_n = 1'b1;
        model_reset();

        // Idle frame: background only, raster pulse counts.
        first_px = -1;
        de_seen = 0; hs_seen = 0; vs_seen = 0;
        for (int i = 0; i < F_TOTAL; i++) step(1'b0, 1'b0, 0);
        check("idle de count", de_seen, 192);
        check("idle hs count", hs_seen, 2 * V_TOTAL);
        check("idle vs count", vs_seen, H_TOTAL);
        check("idle first pixel", first_px, 0);
        check("idle frame_ready", int'(frame_ready), 0);

        // Table of frame feeds started just after a display frame start.
        foreach (vecs[k]) begin
            run_to(1);
            feed(vecs[k].base, vecs[k].npix);
            show_frame();
            check($sformatf("vec%0d first pixel", k), first_px, vecs[k].exp_first);
            check($sformatf("vec%0d last pixel", k), last_px, vecs[k].exp_last);
            check($sformatf("vec%0d frame_ready", k), int'(frame_ready), int'(vecs[k].exp_ready));
            check($sformatf("vec%0d de count", k), de_seen, 192);
        end

        // Back-to-back frames: the second starts while the first is pending and is dropped.
        run_to(1);
        feed(3000, 192);
`ifdef FB_SCANOUT_DROP_CNT_EN
        begin
            int before;
            before = int'(drop_cnt);
            feed(4000, 192);
            check("b2b drop_cnt delta", int'(drop_cnt) - before, 1);
        end
`else
        feed(4000, 192);
`endif
        show_frame();
        check("b2b first pixel", first_px, 3000);
        check("b2b last pixel", last_px, 3191);

        // Reset mid-scan with a frame pending.
        run_to(1);
        feed(7000, 192);
        run_to(100);
        check("pre-reset de", int'(video_de), 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid-scan reset outputs",
              int'({video_hs, video_vs, video_de, frame_ready, video_data}), 0);
        @(negedge clk);
        data_vs = 1'b0; data_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        show_frame();
        check("post-reset frame_ready", int'(frame_ready), 0);
        check("post-reset first pixel", first_px, 0);
        run_to(1);
        feed(9000, 192);
        show_frame();
        check("post-reset new frame first", first_px, 9000);
        check("post-reset new frame last", last_px, 9191);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++)
            step($urandom_range(0, 299) == 0, $urandom_range(0, 9) < 8, $urandom);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
